// File: rtl/vga_sync_rx.sv
// VGA sync receiver: recovers pixel/line position from hs/vs, checks line/frame timing, reports lock.
// Optional statistics ports (err_cnt, frame_cnt) are enabled by defining VGA_SYNC_RX_STATS_EN.
module vga_sync_rx #(
  parameter int PLD         = 800,
  parameter int LFD         = 521,
  parameter int PAL         = 640,
  parameter int LAF         = 480,
  parameter int HFP         = 16,
  parameter int VFP         = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_tick,
  input  logic        hs,
  input  logic        vs,
  output logic [9:0]  p_x,
  output logic [9:0]  p_y,
  output logic        video_on,
  output logic        locked,
  output logic        err,
  output logic        frame_start
`ifdef VGA_SYNC_RX_STATS_EN
  ,
  output logic [7:0]  err_cnt,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [9:0] X_LAST = 10'(PLD - 1);
  localparam logic [9:0] X_LOAD = 10'(PAL + HFP);
  localparam logic [9:0] Y_LAST = 10'(LFD - 1);
  localparam logic [9:0] Y_LOAD = 10'(LAF + VFP);
  localparam logic [9:0] PLD_W  = 10'(PLD);
  localparam logic [9:0] LFD_W  = 10'(LFD);
  localparam logic [9:0] PAL_W  = 10'(PAL);
  localparam logic [9:0] LAF_W  = 10'(LAF);
  localparam logic [7:0] LOCK_W = 8'(LOCK_FRAMES);
  localparam logic [9:0] SAT    = 10'd1023;

  logic       hs_q, vs_q;
  logic       hs_seen, vs_seen;
  logic       vs_pend;
  logic       frame_bad;
  logic [9:0] line_len;
  logic [9:0] line_cnt;
  logic [7:0] good_cnt;

  logic       hs_fall, vs_fall, x_wrap;
  logic       line_viol, sat_viol, frame_viol, viol, good_frame;
  logic [9:0] px_nxt, py_nxt;
  logic [7:0] good_nxt;
  logic       locked_nxt;

  assign hs_fall    = hs_q & ~hs;
  assign vs_fall    = vs_q & ~vs;
  assign x_wrap     = ~hs_fall && (p_x == X_LAST);

  // Checks only start once a first edge has established a reference point.
  assign line_viol  = hs_fall && hs_seen && (line_len != PLD_W);
  assign sat_viol   = ~hs_fall && hs_seen && (line_len == SAT - 10'd1);
  assign frame_viol = vs_fall && vs_seen && (line_cnt != LFD_W);
  assign viol       = line_viol | sat_viol | frame_viol;
  assign good_frame = vs_fall && vs_seen && ~frame_bad;

  always_comb begin
    px_nxt = p_x;
    py_nxt = p_y;
    if (hs_fall)             px_nxt = X_LOAD;
    else if (p_x == X_LAST)  px_nxt = '0;
    else                     px_nxt = p_x + 10'd1;
    if (x_wrap) begin
      if (vs_pend || vs_fall) py_nxt = Y_LOAD;
      else if (p_y == Y_LAST) py_nxt = '0;
      else                    py_nxt = p_y + 10'd1;
    end
  end

  // A violation always wins over the good-frame increment.
  always_comb begin
    good_nxt = good_cnt;
    if (viol)                                     good_nxt = '0;
    else if (good_frame && (good_cnt < LOCK_W))   good_nxt = good_cnt + 8'd1;
  end

  assign locked_nxt = (good_nxt == LOCK_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      hs_seen     <= 1'b0;
      vs_seen     <= 1'b0;
      vs_pend     <= 1'b0;
      frame_bad   <= 1'b0;
      line_len    <= '0;
      line_cnt    <= '0;
      good_cnt    <= '0;
      p_x         <= '0;
      p_y         <= '0;
      video_on    <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
      frame_start <= 1'b0;
`ifdef VGA_SYNC_RX_STATS_EN
      err_cnt     <= '0;
      frame_cnt   <= '0;
`endif
    end else begin
      err         <= 1'b0;
      frame_start <= 1'b0;
      if (p_tick) begin
        hs_q        <= hs;
        vs_q        <= vs;
        hs_seen     <= hs_seen | hs_fall;
        vs_seen     <= vs_seen | vs_fall;
        vs_pend     <= x_wrap ? 1'b0 : (vs_pend | vs_fall);
        frame_bad   <= vs_fall ? 1'b0 : (frame_bad | viol);
        if (hs_fall)              line_len <= 10'd1;
        else if (line_len != SAT) line_len <= line_len + 10'd1;
        // An hs edge on the vs tick belongs to the new frame.
        if (vs_fall)                         line_cnt <= {9'd0, hs_fall};
        else if (hs_fall && line_cnt != SAT) line_cnt <= line_cnt + 10'd1;
        good_cnt    <= good_nxt;
        p_x         <= px_nxt;
        p_y         <= py_nxt;
        locked      <= locked_nxt;
        video_on    <= locked_nxt && (px_nxt < PAL_W) && (py_nxt < LAF_W);
        err         <= viol;
        frame_start <= vs_fall;
`ifdef VGA_SYNC_RX_STATS_EN
        if (viol && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
        if (vs_fall)                  frame_cnt <= frame_cnt + 16'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Self-checking bench for vga_sync_rx with a shrunken timing grid and a tick-level reference model.
// Stats ports are exercised when VGA_SYNC_RX_STATS_EN is defined.
module tb_vga_sync_rx;

  localparam int PLD = 20, LFD = 12, PAL = 12, LAF = 8, HFP = 2, VFP = 1, LOCK = 2;
  localparam int HS_START = PAL + HFP, HS_W = 3, VS_START = LAF + VFP;
  localparam int FRAME_T = PLD * LFD;

  logic       clk = 1'b0, rst_n = 1'b0, p_tick = 1'b0, hs = 1'b1, vs = 1'b1;
  logic [9:0] p_x, p_y;
  logic       video_on, locked, err, frame_start;
`ifdef VGA_SYNC_RX_STATS_EN
  logic [7:0]  err_cnt;
  logic [15:0] frame_cnt;
`endif

  vga_sync_rx #(.PLD(PLD), .LFD(LFD), .PAL(PAL), .LAF(LAF), .HFP(HFP), .VFP(VFP),
                .LOCK_FRAMES(LOCK)) dut (
    .clk(clk), .rst_n(rst_n), .p_tick(p_tick), .hs(hs), .vs(vs),
    .p_x(p_x), .p_y(p_y), .video_on(video_on), .locked(locked),
    .err(err), .frame_start(frame_start)
`ifdef VGA_SYNC_RX_STATS_EN
    , .err_cnt(err_cnt), .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: timestamps of the last edges and plain counts of events.
  int m_t, m_last_hs, m_lines, m_good, m_px, m_py, m_viol_total, m_vs_total;
  bit m_hs_prev, m_vs_prev, m_hs_seen, m_vs_seen, m_bad, m_pend, m_err, m_fs;

  task automatic model_reset();
    m_t = 0; m_last_hs = 0; m_lines = 0; m_good = 0; m_px = 0; m_py = 0;
    m_viol_total = 0; m_vs_total = 0;
    m_hs_prev = 0; m_vs_prev = 0; m_hs_seen = 0; m_vs_seen = 0;
    m_bad = 0; m_pend = 0; m_err = 0; m_fs = 0;
  endtask

  task automatic model_tick(input bit h, input bit v);
    bit hf, vf, viol, wrap;
    m_t++;
    hf = m_hs_prev && !h;
    vf = m_vs_prev && !v;
    m_hs_prev = h;
    m_vs_prev = v;
    viol = 0;
    if (hf) begin
      if (m_hs_seen && (m_t - m_last_hs) != PLD) viol = 1;
      m_last_hs = m_t;
      m_hs_seen = 1;
    end else if (m_hs_seen && (m_t - m_last_hs + 1) == 1023) begin
      viol = 1;
    end
    if (vf && m_vs_seen && m_lines != LFD) viol = 1;
    if (vf && m_vs_seen && !viol && !m_bad && m_good < LOCK) m_good++;
    if (viol) m_good = 0;
    m_bad = vf ? 1'b0 : (m_bad | viol);
    if (vf) m_vs_seen = 1;
    m_lines = vf ? int'(hf) : m_lines + int'(hf);
    wrap = !hf && (m_px == PLD - 1);
    m_pend = m_pend | vf;
    m_px = hf ? HS_START : (m_px + 1) % PLD;
    if (wrap) begin
      m_py = m_pend ? VS_START : (m_py + 1) % LFD;
      m_pend = 0;
    end
    m_err = viol;
    m_fs = vf;
    m_viol_total += int'(viol);
    m_vs_total += int'(vf);
  endtask

  function automatic logic [23:0] exp_outs();
    bit lck, vid;
    lck = (m_good == LOCK);
    vid = lck && (m_px < PAL) && (m_py < LAF);
    return {10'(m_px), 10'(m_py), vid, lck, m_err, m_fs};
  endfunction

  // Stimulus generator: position on the ideal grid, with optional defects.
  int g_x, g_y, g_len, g_flen, g_short;
  bit g_short_frame, g_hold;

  task automatic gen_reset(input int x, input int y);
    g_x = x; g_y = y; g_len = PLD; g_flen = LFD; g_short = 0;
    g_short_frame = 0; g_hold = 0;
  endtask

  task automatic gen(output bit h, output bit v);
    h = !(g_x >= HS_START && g_x < HS_START + HS_W) || g_hold;
    v = !(g_y >= VS_START && g_y < VS_START + 2) || g_hold;
    g_x++;
    if (g_x >= g_len) begin
      g_x = 0;
      if (g_short > 0) begin g_len = PLD - 1; g_short--; end
      else g_len = PLD;
      g_y++;
      if (g_y >= g_flen) begin
        g_y = 0;
        g_flen = g_short_frame ? LFD - 1 : LFD;
        g_short_frame = 0;
      end
    end
  endtask

  int obs_err, obs_fs, obs_both, obs_max_px, lock_rise_fs, cyc_i, tick_mode;
  bit prev_locked;

  task automatic clear_obs();
    obs_err = 0; obs_fs = 0; obs_both = 0; obs_max_px = 0; lock_rise_fs = -1;
  endtask

  task automatic step(input bit t);
    bit h, v;
    if (t) begin
      gen(h, v);
      hs = h; vs = v; p_tick = 1'b1;
      model_tick(h, v);
    end else begin
      p_tick = 1'b0;
      hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      m_err = 0; m_fs = 0;
    end
    cyc_i++;
    @(posedge clk);
    @(negedge clk);
    chk("outs", {p_x, p_y, video_on, locked, err, frame_start}, exp_outs());
    if (err) obs_err++;
    if (frame_start) obs_fs++;
    if (err && frame_start) obs_both++;
    if (int'(p_x) > obs_max_px) obs_max_px = int'(p_x);
    if (locked && !prev_locked && lock_rise_fs < 0) lock_rise_fs = obs_fs;
    prev_locked = locked;
  endtask

  task automatic run_ticks(input int n);
    int done = 0;
    int budget = n * 8 + 100;
    while (done < n && budget > 0) begin
      bit t;
      case (tick_mode)
        0:       t = (cyc_i % 4 == 0);
        1:       t = ($urandom_range(0, 2) != 0);
        default: t = 1'b1;
      endcase
      step(t);
      if (t) done++;
      budget--;
    end
    chk("tick_budget", 64'(done), 64'(n));
  endtask

  int vs_mark;

  initial begin
    model_reset();
    gen_reset(0, 0);
    cyc_i = 0; tick_mode = 0; prev_locked = 0;
    clear_obs();
    repeat (3) @(negedge clk);
    chk("reset_outs", {p_x, p_y, video_on, locked, err, frame_start}, 24'd0);
    rst_n = 1'b1;

    // Ideal timing, tick every 4th clock.
    run_ticks(4 * FRAME_T);
    chk("p1_no_err", 64'(obs_err), 0);
    chk("p1_lock_at_vs3", 64'(lock_rise_fs), 64'(LOCK + 1));
    chk("p1_locked", 64'(locked), 1);

    // One line a tick short.
    tick_mode = 1;
    clear_obs();
    g_short = 1;
    run_ticks(60);
    chk("p2_err_once", 64'(obs_err), 1);
    chk("p2_unlocked", 64'(locked), 0);
    run_ticks(3 * FRAME_T + 20);
    chk("p2_relock", 64'(locked), 1);
    chk("p2_err_total", 64'(obs_err), 1);

    // Syncs held high: line-length saturation.
    tick_mode = 2;
    clear_obs();
    g_hold = 1;
    run_ticks(1100);
    chk("p3_sat_err", 64'(obs_err), 1);
    chk("p3_unlocked", 64'(locked), 0);
    chk("p3_px_wrap", 64'(obs_max_px), 64'(PLD - 1));
    g_hold = 0;
    run_ticks(5 * FRAME_T);
    chk("p3_relock", 64'(locked), 1);

    // One frame a line short.
    tick_mode = 1;
    clear_obs();
    vs_mark = m_vs_total;
    g_short_frame = 1;
    run_ticks(700);
    chk("p4_err_at_vs", 64'(obs_both), 1);
    chk("p4_err_once", 64'(obs_err), 1);
    chk("p4_unlocked", 64'(locked), 0);
    chk("p4_fs_count", 64'(obs_fs), 64'(m_vs_total - vs_mark));
    run_ticks(600);
    chk("p4_relock", 64'(locked), 1);

    // Asynchronous reset mid-line.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("rst_async", {p_x, p_y, video_on, locked, err, frame_start}, 24'd0);
`ifdef VGA_SYNC_RX_STATS_EN
    chk("rst_stats", {err_cnt, frame_cnt}, 24'd0);
`endif
    p_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    gen_reset(7, 3);
    prev_locked = 0;
    rst_n = 1'b1;
    clear_obs();
    run_ticks(3 * FRAME_T + 100);
    chk("p5_no_err", 64'(obs_err), 0);
    chk("p5_relock", 64'(locked), 1);

    // 300 short lines.
    clear_obs();
    g_short = 300;
    run_ticks(PLD + 300 * (PLD - 1) + PLD);
    chk("p6_err_lines", 64'(obs_err), 300);
`ifdef VGA_SYNC_RX_STATS_EN
    chk("p6_err_cnt_sat", 64'(err_cnt), 64'(m_viol_total > 255 ? 255 : m_viol_total));
    chk("p6_err_cnt_255", 64'(err_cnt), 255);
    chk("p6_frame_cnt", 64'(frame_cnt), 64'(m_vs_total % 65536));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_rx.md
VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameter PLD, 800, pixel ticks per line.
REQ-002 Parameter LFD, 521, lines per frame.
REQ-003 Parameter PAL, 640, active pixels per line.
REQ-004 Parameter LAF, 480, active lines per frame.
REQ-005 Parameter HFP, 16, horizontal front porch in ticks.
REQ-006 Parameter VFP, 10, vertical front porch in lines.
REQ-007 Parameter LOCK_FRAMES, 2, consecutive good frames required to assert locked.
REQ-008 clk  input  1  system clock; the only clock in the block.
REQ-009 rst_n  input  1  reset, asynchronous and active-low.
REQ-010 p_tick  input  1  pixel-rate enable, synchronous to clk.
REQ-011 hs  input  1  horizontal sync, active low.
REQ-012 vs  input  1  vertical sync, active low.
REQ-013 p_x  output  10  recovered pixel column.
REQ-014 p_y  output  10  recovered line number.
REQ-015 video_on  output  1  high when locked, p_x<PAL and p_y<LAF.
REQ-016 locked  output  1  timing matches parameters.
REQ-017 err  output  1  one-clk pulse on any timing violation.
REQ-018 frame_start  output  1  one-clk pulse on each detected vs falling edge.

Function
REQ-019 All state SHALL update only on clk rising edges with p_tick=1; with p_tick=0 all registers hold, and err/frame_start are 0.
REQ-020 hs and vs SHALL be registered on each tick; a falling edge is detected when the registered value was 1 and the current sample is 0.
REQ-021 On an hs falling edge, p_x SHALL load PAL+HFP; otherwise p_x SHALL increment, wrapping from PLD-1 to 0.
REQ-022 On a p_x wrap, p_y SHALL increment, wrapping from LFD-1 to 0; if a vs falling edge occurred since the previous wrap, p_y SHALL load LAF+VFP instead.
REQ-023 A 10-bit line-length counter SHALL count ticks between hs falling edges, saturating at 1023; at each hs edge, a count other than PLD SHALL flag a line violation (the first edge after reset is exempt).
REQ-024 A saturation of the line-length counter at 1023 SHALL flag a violation once, without waiting for an hs edge.
REQ-025 A line counter SHALL count hs falling edges between vs falling edges; at each vs edge, a count other than LFD SHALL flag a frame violation (the first vs edge after reset is exempt).
REQ-026 Each vs falling edge SHALL pulse frame_start on that tick.
REQ-027 Good-frame counter: at each vs edge, increments (saturating at LOCK_FRAMES) if the completed frame had no violation.
REQ-028 locked SHALL rise on the tick the good-frame counter reaches LOCK_FRAMES.
REQ-029 Any violation SHALL, on the same tick, pulse err, clear locked and clear the good-frame counter; the current frame then counts as bad.
REQ-030 A violation coincident with a vs edge SHALL take priority over the good-frame increment.
REQ-031 Outputs SHALL be registered; video_on SHALL be derived from the registered p_x, p_y and locked.

Reset
REQ-032 Asserting rst_n=0 SHALL immediately clear p_x, p_y, video_on, locked, err, frame_start, all counters, edge history and "first edge" exemption flags, including mid-frame.
REQ-033 After reset release, the first hs and vs edges SHALL re-establish alignment without flagging errors.

Configuration
REQ-034 With macro VGA_SYNC_RX_STATS_EN defined, outputs err_cnt[7:0] (violations, saturating at 255) and frame_cnt[15:0] (vs edges, wrapping) SHALL exist and reset to 0.
REQ-035 Without VGA_SYNC_RX_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-036 Drive ideal 800x521 timing (hs low ticks 656-751, vs low lines 490-491), p_tick every 4th clk, for 4 frames -> no err; locked rises at the third vs edge; video_on=1 exactly when p_x<640 and p_y<480.
REQ-037 Once locked, shorten one line to 799 ticks -> err pulses once at the next hs edge and locked drops that tick; locked returns after 2 further good frames.
REQ-038 Hold hs high while locked -> err pulses when 1023 ticks elapse since the last edge, locked=0, and p_x continues wrapping at 800.
REQ-039 Drive a 520-line frame -> err at the vs edge; frame_start still pulses; good-frame counter resets to 0.
REQ-040 Assert rst_n low mid-line between clk edges -> all outputs 0 immediately; after release, no err on the first hs/vs edges.
REQ-041 With VGA_SYNC_RX_STATS_EN, run 300 violating lines -> err_cnt saturates at 255; frame_cnt equals the number of vs edges.
